// File: rtl/game_pkg.sv
// Shared types and constants for the penalty shoot-out game.
package game_pkg;

  localparam int ROUNDS_DEFAULT = 5;
  localparam int SCORE_W        = 4;

  typedef enum logic [2:0] {
    START   = 3'd0,
    KEEPER  = 3'd1,
    SHOOTER = 3'd2,
    WINNER  = 3'd3,
    LOSER   = 3'd4
  } g_state;

  typedef enum logic [0:0] {
    SOLO  = 1'b0,
    MULTI = 1'b1
  } g_mode;

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
    if (v == {SCORE_W{1'b1}}) begin
      sat_inc = v;
    end else begin
      sat_inc = v + {{(SCORE_W-1){1'b0}}, 1'b1};
    end
  endfunction

endpackage

// File: rtl/game_turn_timer.sv
// Per-turn timer: flags the last allowed cycle of a turn while enabled.
module game_turn_timer #(
  parameter int TURN_TICKS = 195_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = (TURN_TICKS > 1) ? $clog2(TURN_TICKS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TURN_TICKS - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: held at zero outside a turn and on every state change.
  always_comb begin
    cnt_d = cnt_q;
    if (clear || !enable) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (cnt_q == LAST) begin
      cnt_d = {CNT_W{1'b0}};
    end else begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = enable && (cnt_q == LAST);

endmodule

// File: rtl/game_round_ctl.sv
// Penalty shoot-out round sequencer: owns game state, mode, scores and round.
// Optional EARLY_DECIDE_EN ends regulation once a lead can no longer be caught.
module game_round_ctl
  import game_pkg::*;
#(
  parameter int ROUNDS     = ROUNDS_DEFAULT,
  parameter int TURN_TICKS = 195_000_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               btn_start,
  input  g_mode              mode_sel,
  input  logic               shot_valid,
  input  logic               shot_goal,
  output g_state             game_state,
  output g_mode              game_mode,
  output logic [SCORE_W-1:0] score_player,
  output logic [SCORE_W-1:0] score_cpu,
  output logic [3:0]         round_idx,
  output logic               turn_start
);

  g_state             state_q, state_d;
  g_mode              mode_q, mode_d;
  logic [SCORE_W-1:0] sp_q, sp_d, sc_q, sc_d;
  logic [SCORE_W-1:0] sp_new_s, sc_new_s;
  logic [3:0]         round_q, round_d;
  logic               turn_start_q, turn_start_d;
  logic               round_adv_s;
  logic               in_turn_s, expired_s, resolve_s, goal_s, last_round_s;

  assign in_turn_s    = (state_q == SHOOTER) || (state_q == KEEPER);
  assign resolve_s    = in_turn_s && (shot_valid || expired_s);
  assign goal_s       = shot_valid && shot_goal;
  assign last_round_s = ({1'b0, round_q} + 5'd1) >= 5'(ROUNDS);

`ifdef EARLY_DECIDE_EN
  logic       regulation_s;
  logic [4:0] rem_after_s, rem_cur_s, p_rem_s, c_rem_s;
  assign regulation_s = {1'b0, round_q} < 5'(ROUNDS);
  assign rem_cur_s    = 5'(ROUNDS) - {1'b0, round_q};
  assign rem_after_s  = rem_cur_s - 5'd1;
  assign p_rem_s      = rem_after_s;
  assign c_rem_s      = (state_q == SHOOTER) ? rem_cur_s : rem_after_s;
`endif

  game_turn_timer #(.TURN_TICKS(TURN_TICKS)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (state_d != state_q),
    .enable  (in_turn_s),
    .expired (expired_s)
  );

  // Next state plus the scores after the resolving shot.
  always_comb begin
    state_d     = state_q;
    sp_new_s    = sp_q;
    sc_new_s    = sc_q;
    round_adv_s = 1'b0;
    case (state_q)
      START: begin
        if (btn_start) state_d = SHOOTER;
        else           state_d = START;
      end
      SHOOTER: begin
        if (resolve_s) begin
          if (goal_s) sp_new_s = sat_inc(sp_q);
          else        sp_new_s = sp_q;
          state_d = KEEPER;
        end else begin
          state_d = SHOOTER;
        end
      end
      KEEPER: begin
        if (resolve_s) begin
          if (goal_s) sc_new_s = sat_inc(sc_q);
          else        sc_new_s = sc_q;
          if (!last_round_s || (sp_new_s == sc_new_s)) begin
            state_d     = SHOOTER;
            round_adv_s = 1'b1;
          end else if (sp_new_s > sc_new_s) begin
            state_d = WINNER;
          end else begin
            state_d = LOSER;
          end
        end else begin
          state_d = KEEPER;
        end
      end
      WINNER, LOSER: begin
        if (btn_start) state_d = START;
        else           state_d = state_q;
      end
      default: state_d = START;
    endcase
`ifdef EARLY_DECIDE_EN
    // A lead larger than the trailing side's remaining kicks is decisive.
    if (resolve_s && regulation_s) begin
      if ((sp_new_s > sc_new_s) && ({1'b0, sp_new_s - sc_new_s} > c_rem_s)) begin
        state_d     = WINNER;
        round_adv_s = 1'b0;
      end else if ((sc_new_s > sp_new_s) && ({1'b0, sc_new_s - sp_new_s} > p_rem_s)) begin
        state_d     = LOSER;
        round_adv_s = 1'b0;
      end else begin
        state_d = state_d;
      end
    end else begin
      state_d = state_d;
    end
`endif
  end

  // Next values of the registered outputs.
  always_comb begin
    mode_d       = mode_q;
    sp_d         = sp_new_s;
    sc_d         = sc_new_s;
    round_d      = round_q;
    turn_start_d = (state_d != state_q) && ((state_d == SHOOTER) || (state_d == KEEPER));
    if ((state_q == START) && btn_start) begin
      mode_d  = mode_sel;
      sp_d    = {SCORE_W{1'b0}};
      sc_d    = {SCORE_W{1'b0}};
      round_d = 4'd0;
    end else if (round_adv_s) begin
      round_d = sat_inc(round_q);
    end else begin
      round_d = round_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= START;
      mode_q       <= SOLO;
      sp_q         <= {SCORE_W{1'b0}};
      sc_q         <= {SCORE_W{1'b0}};
      round_q      <= 4'd0;
      turn_start_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      sp_q         <= sp_d;
      sc_q         <= sc_d;
      round_q      <= round_d;
      turn_start_q <= turn_start_d;
    end
  end

  assign game_state   = state_q;
  assign game_mode    = mode_q;
  assign score_player = sp_q;
  assign score_cpu    = sc_q;
  assign round_idx    = round_q;
  assign turn_start   = turn_start_q;

endmodule

// File: tb/tb_game_round_ctl.sv
// Directed bench for game_round_ctl (ROUNDS=5, TURN_TICKS=100).
module tb_game_round_ctl;
  import game_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_start = 1'b0;
  g_mode      mode_sel = SOLO;
  logic       shot_valid = 1'b0;
  logic       shot_goal = 1'b0;
  g_state     game_state;
  g_mode      game_mode;
  logic [3:0] score_player, score_cpu, round_idx;
  logic       turn_start;

  int n_checks = 0;
  int n_errors = 0;

  game_round_ctl #(.ROUNDS(5), .TURN_TICKS(100)) dut (
    .clk(clk), .rst(rst), .btn_start(btn_start), .mode_sel(mode_sel),
    .shot_valid(shot_valid), .shot_goal(shot_goal), .game_state(game_state),
    .game_mode(game_mode), .score_player(score_player), .score_cpu(score_cpu),
    .round_idx(round_idx), .turn_start(turn_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_game(input string tag, input g_state st, input int sp, input int sc, input int rnd);
    chk({tag, ".state"}, 32'(game_state), 32'(st));
    chk({tag, ".sp"}, 32'(score_player), 32'(sp));
    chk({tag, ".sc"}, 32'(score_cpu), 32'(sc));
    chk({tag, ".round"}, 32'(round_idx), 32'(rnd));
  endtask

  // All tasks start and end on a falling edge.
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic shot(input logic goal);
    shot_valid = 1'b1;
    shot_goal  = goal;
    @(negedge clk);
    shot_valid = 1'b0;
    shot_goal  = 1'b0;
  endtask

  task automatic press(input g_mode m);
    mode_sel  = m;
    btn_start = 1'b1;
    @(negedge clk);
    btn_start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(3);
    rst = 1'b0;
    chk_game("reset", START, 0, 0, 0);
    chk("reset.mode", 32'(game_mode), 32'(SOLO));
    chk("reset.ts", 32'(turn_start), 32'd0);

    shot(1'b1);
    chk("start_ignores_shot", 32'(game_state), 32'(START));

    press(MULTI);
    chk_game("go", SHOOTER, 0, 0, 0);
    chk("go.mode", 32'(game_mode), 32'(MULTI));
    chk("go.ts", 32'(turn_start), 32'd1);
    tick(1);
    chk("go.ts_low", 32'(turn_start), 32'd0);

    // Player always scores, cpu always misses.
    shot(1'b1);
    chk_game("a1", KEEPER, 1, 0, 0);
    chk("a1.ts", 32'(turn_start), 32'd1);
    shot(1'b0);
    chk_game("a2", SHOOTER, 1, 0, 1);
    for (int i = 2; i < 10; i++) begin
      if (game_state == WINNER) break;
      shot((i % 2) == 0);
    end
`ifdef EARLY_DECIDE_EN
    chk_game("a_end", WINNER, 3, 0, 2);
`else
    chk_game("a_end", WINNER, 5, 0, 4);
`endif
    chk("a_end.ts", 32'(turn_start), 32'd0);
    press(SOLO);
    chk("a_back.state", 32'(game_state), 32'(START));
    chk("a_back.mode", 32'(game_mode), 32'(MULTI));

    // Tie after regulation, sudden death.
    press(SOLO);
    chk_game("b0", SHOOTER, 0, 0, 0);
    chk("b0.mode", 32'(game_mode), 32'(SOLO));
    for (int i = 0; i < 10; i++) shot(1'b1);
    chk_game("b_tie", SHOOTER, 5, 5, 5);
    chk("b_tie.ts", 32'(turn_start), 32'd1);
    shot(1'b1);
    chk_game("b_sd1", KEEPER, 6, 5, 5);
    press(MULTI);
    chk_game("b_btn_keeper", KEEPER, 6, 5, 5);
    shot(1'b0);
    chk_game("b_end", WINNER, 6, 5, 5);
    press(SOLO);
    chk_game("b_back", START, 6, 5, 5);

    // Turn timeouts.
    press(MULTI);
    tick(99);
    chk_game("c_t99", SHOOTER, 0, 0, 0);
    tick(1);
    chk_game("c_t100", KEEPER, 0, 0, 0);
    chk("c_t100.ts", 32'(turn_start), 32'd1);
    tick(99);
    shot(1'b1);
    chk_game("c_k_coinc", SHOOTER, 0, 1, 1);
    tick(99);
    shot(1'b1);
    chk_game("c_s_coinc", KEEPER, 1, 1, 1);
    rst        = 1'b1;
    shot_valid = 1'b1;
    shot_goal  = 1'b1;
    tick(1);
    rst        = 1'b0;
    shot_valid = 1'b0;
    shot_goal  = 1'b0;
    chk_game("c_rst", START, 0, 0, 0);
    chk("c_rst.mode", 32'(game_mode), 32'(SOLO));
    chk("c_rst.ts", 32'(turn_start), 32'd0);

    // 3-0 after the player's 4th kick.
    press(SOLO);
    shot(1'b0); shot(1'b0);
    shot(1'b1); shot(1'b0);
    shot(1'b1); shot(1'b0);
    shot(1'b1);
`ifdef EARLY_DECIDE_EN
    chk_game("d_early", WINNER, 3, 0, 3);
`else
    chk_game("d_early", KEEPER, 3, 0, 3);
    shot(1'b0);
    chk_game("d_r4", SHOOTER, 3, 0, 4);
    shot(1'b0); shot(1'b0);
    chk_game("d_end", WINNER, 3, 0, 4);
`endif
    press(SOLO);

    // Cpu always scores, player always misses.
    press(SOLO);
    for (int i = 0; i < 10; i++) begin
      if (game_state == LOSER) break;
      shot((i % 2) == 1);
    end
`ifdef EARLY_DECIDE_EN
    chk_game("e_end", LOSER, 0, 3, 2);
`else
    chk_game("e_end", LOSER, 0, 5, 4);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
